pressure_scan_controller: RTL and testbench
===========================================

# pressure_scan_controller

Sequencing controller for the shared 8-bit pressure ADC converter. It scans NUM_CH multiplexed sensor channels round-robin. For each channel it drives the analog mux select, waits for input settling and the converter pipeline latency, then averages 2^AVG_LOG2 consecutive converter outputs. Each averaged result is presented to the downstream consumer over a valid/ready handshake.

## Interface
- NUM_CH, 4: number of sensor channels, 2..16.
- SETTLE_CYC, 8: mux settling cycles after a channel switch, ≥1.
- CONV_LAT, 2: converter input-to-output latency in cycles, ≥1.
- AVG_LOG2, 2: log2 of samples averaged per channel, 0..4.
- CHW, $clog2(NUM_CH): channel index width (derived).
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  level; high = keep scanning, low = stop after the current channel.
- ch_sel  out  CHW  analog mux select for the converter input.
- conv_data  in  8  converter digital output.
- res_valid  out  1  averaged result available.
- res_ready  in  1  consumer accepts result.
- res_ch  out  CHW  channel index of the presented result.
- res_data  out  8  averaged result.
- busy  out  1  high whenever state ≠ IDLE.
- scan_done  out  1  one-cycle pulse when the result for channel NUM_CH-1 is accepted.

## Operation
- States and transitions:
  - IDLE → SETTLE when enable=1.
  - SETTLE → WAIT_CONV after SETTLE_CYC cycles.
  - WAIT_CONV → SAMPLE after CONV_LAT cycles.
  - SAMPLE → PRESENT after 2^AVG_LOG2 cycles.
  - PRESENT → SETTLE on handshake if enable=1; PRESENT → IDLE on handshake if enable=0.
- Handshake = res_valid & res_ready.
- Single down-counter shared by SETTLE, WAIT_CONV and SAMPLE. Loaded with N-1 on state entry; the state exits in the cycle the counter reads 0.
- SAMPLE:
  - Accumulator is (8+AVG_LOG2) bits wide, cleared on SETTLE entry.
  - acc += conv_data on every SAMPLE cycle. No overflow is possible by construction.
- On SAMPLE exit: res_data = acc >> AVG_LOG2 (truncating), res_ch = ch_sel. Both registered and held stable through PRESENT.
- Channel advance:
  - On handshake, ch_sel increments, wrapping from NUM_CH-1 to 0.
  - On entry to IDLE, ch_sel is forced to 0.
- scan_done pulses in the cycle after a handshake where res_ch = NUM_CH-1.
- enable is sampled only in IDLE and at the PRESENT handshake. Deasserting enable mid-channel does not abort the channel: the result is completed, presented and must be accepted.
- Backpressure: PRESENT holds indefinitely while res_ready=0. No samples are taken and no data is dropped.
- Asynchronous reset, applied at any point including mid-scan:
  - State goes to IDLE; counter and accumulator clear.
  - Outputs: ch_sel=0, res_valid=0, res_ch=0, res_data=0, busy=0, scan_done=0.
  - An in-flight result is discarded.

## Timing
- All outputs are registered. No combinational path from res_ready to res_valid.
- Take edge E0 as the edge where enable=1 is sampled in IDLE:
  - busy=1 and state=SETTLE from E0.
  - res_valid rises at E0 + SETTLE_CYC + CONV_LAT + 2^AVG_LOG2.
  - With defaults this is E0+14.
- The SAMPLE window covers edges E0+SETTLE_CYC+CONV_LAT through E0+SETTLE_CYC+CONV_LAT+2^AVG_LOG2-1.
- At handshake edge H:
  - res_valid=0 from H.
  - The new ch_sel is valid from H.
  - SETTLE restarts at H. The next result is valid at H + SETTLE_CYC + CONV_LAT + 2^AVG_LOG2.
- Per-channel period with res_ready tied high: SETTLE_CYC + CONV_LAT + 2^AVG_LOG2 + 1 cycles (15 with defaults).
- Reset deassertion must be synchronized externally. The first active edge after deassertion observes IDLE.

## Test plan
- Reset values: assert reset low mid-SAMPLE → all outputs read 0 immediately, without waiting for a clock edge. After release with enable=1, the scan restarts at ch 0.
- Single scan, defaults: conv_data held at 0x80 on all channels, res_ready=1 → four results, res_ch 0,1,2,3, res_data=0x80. First res_valid at E0+14, then every 15 cycles. scan_done pulses once after ch 3.
- Averaging and truncation: conv_data = 0x01, 0x02, 0x02, 0x02 across the SAMPLE window → res_data=0x01 (sum 7 >> 2). With all samples 0xFF → res_data=0xFF, no overflow.
- Backpressure: hold res_ready=0 for 20 cycles at PRESENT → res_valid, res_data and res_ch stay stable, ch_sel is unchanged, no extra samples are taken. Accepted on the 21st cycle.
- Stop mid-scan: drop enable during ch 1 SETTLE → ch 1 result is still produced and accepted. The controller then goes to IDLE with busy=0 and ch_sel=0, and no ch 2 result follows.
- Wrap-around: NUM_CH=3, continuous enable → res_ch sequence 0,1,2,0,1,2. scan_done pulses after each ch 2 acceptance.

Source files
------------

// File: rtl/pressure_scan_controller.sv
// Round-robin scan sequencer for a shared 8-bit pressure ADC: mux select, settle,
// converter latency, 2^AVG_LOG2-sample averaging, valid/ready result handoff.
`timescale 1ns/1ps
module pressure_scan_controller #(
  parameter int NUM_CH     = 4,
  parameter int SETTLE_CYC = 8,
  parameter int CONV_LAT   = 2,
  parameter int AVG_LOG2   = 2,
  parameter int CHW        = $clog2(NUM_CH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  output logic [CHW-1:0] ch_sel,
  input  logic [7:0]     conv_data,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [CHW-1:0] res_ch,
  output logic [7:0]     res_data,
  output logic           busy,
  output logic           scan_done
);

  localparam int ACCW  = 8 + AVG_LOG2;
  localparam int S_MAX = (SETTLE_CYC > CONV_LAT) ? SETTLE_CYC : CONV_LAT;
  localparam int N_MAX = (S_MAX > (1 << AVG_LOG2)) ? S_MAX : (1 << AVG_LOG2);
  localparam int CNTW  = $clog2(N_MAX + 1);

  localparam logic [CNTW-1:0] SETTLE_LD = CNTW'(SETTLE_CYC - 1);
  localparam logic [CNTW-1:0] CONV_LD   = CNTW'(CONV_LAT - 1);
  localparam logic [CNTW-1:0] SAMPLE_LD = CNTW'((1 << AVG_LOG2) - 1);
  localparam logic [CHW-1:0]  LAST_CH   = CHW'(NUM_CH - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    WAIT_CONV,
    SAMPLE,
    PRESENT
  } state_t;

  state_t           state;
  logic [CNTW-1:0]  cnt;
  logic [ACCW-1:0]  acc;
  logic [ACCW-1:0]  sum_next;

  function automatic logic [7:0] avg_trunc(input logic [ACCW-1:0] sum);
    return 8'(sum >> AVG_LOG2);
  endfunction

  // The final sample is folded in on the exit edge, so the result includes it.
  assign sum_next = acc + ACCW'(conv_data);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      ch_sel    <= '0;
      res_valid <= 1'b0;
      res_ch    <= '0;
      res_data  <= '0;
      busy      <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state <= SETTLE;
            cnt   <= SETTLE_LD;
            acc   <= '0;
            busy  <= 1'b1;
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            state <= WAIT_CONV;
            cnt   <= CONV_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WAIT_CONV: begin
          if (cnt == '0) begin
            state <= SAMPLE;
            cnt   <= SAMPLE_LD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SAMPLE: begin
          acc <= sum_next;
          if (cnt == '0) begin
            state     <= PRESENT;
            res_valid <= 1'b1;
            res_data  <= avg_trunc(sum_next);
            res_ch    <= ch_sel;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PRESENT: begin
          // Result is held untouched until the consumer takes it.
          if (res_ready) begin
            res_valid <= 1'b0;
            scan_done <= (res_ch == LAST_CH);
            if (enable) begin
              state  <= SETTLE;
              cnt    <= SETTLE_LD;
              acc    <= '0;
              ch_sel <= (ch_sel == LAST_CH) ? '0 : ch_sel + 1'b1;
            end else begin
              state  <= IDLE;
              ch_sel <= '0;
              busy   <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pressure_scan_controller.sv
// Scoreboard bench for pressure_scan_controller: directed scans push expected
// results; a negedge monitor pops and compares on every handshake.
`timescale 1ns/1ps
module tb_pressure_scan_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       reset, enable, res_ready;
  logic [7:0] conv_data;
  logic [1:0] ch_sel, res_ch;
  logic       res_valid, busy, scan_done;
  logic [7:0] res_data;

  logic       reset3, enable3, res_ready3;
  logic [7:0] conv_data3;
  logic [1:0] ch_sel3, res_ch3;
  logic       res_valid3, busy3, scan_done3;
  logic [7:0] res_data3;

  pressure_scan_controller dut (
    .clk(clk), .reset(reset), .enable(enable), .ch_sel(ch_sel),
    .conv_data(conv_data), .res_valid(res_valid), .res_ready(res_ready),
    .res_ch(res_ch), .res_data(res_data), .busy(busy), .scan_done(scan_done)
  );

  pressure_scan_controller #(
    .NUM_CH(3), .SETTLE_CYC(2), .CONV_LAT(1), .AVG_LOG2(0)
  ) dut3 (
    .clk(clk), .reset(reset3), .enable(enable3), .ch_sel(ch_sel3),
    .conv_data(conv_data3), .res_valid(res_valid3), .res_ready(res_ready3),
    .res_ch(res_ch3), .res_data(res_data3), .busy(busy3), .scan_done(scan_done3)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int ch;
    int data;
    int rise;
  } exp_t;

  exp_t q0[$];
  exp_t q3[$];
  int   prev_v[2];
  int   rise_c[2];
  int   sd_pend[2];
  int   sd_cnt[2];

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cyc %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic push(input int id, input int ch, input int data, input int rise);
    exp_t e;
    e.ch = ch; e.data = data; e.rise = rise;
    if (id == 0) q0.push_back(e);
    else q3.push_back(e);
  endtask

  function automatic int qsize(input int id);
    return (id == 0) ? q0.size() : q3.size();
  endfunction

  task automatic mon_step(input int id, input logic rst_n, input logic v, input logic rdy,
                          input int ch, input int data, input logic sd, input int nch);
    exp_t e;
    if (!rst_n) begin
      prev_v[id]  = 0;
      sd_pend[id] = 0;
      return;
    end
    if (sd) sd_cnt[id]++;
    if (sd_pend[id] != 0 || sd) chk($sformatf("scan_done%0d", id), int'(sd), sd_pend[id]);
    sd_pend[id] = 0;
    if (v && prev_v[id] == 0) rise_c[id] = cyc;
    if (v && rdy) begin
      if (qsize(id) == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result%0d: actual ch=%0d data=0x%0h required none", id, ch, data);
      end else begin
        if (id == 0) e = q0.pop_front();
        else e = q3.pop_front();
        chk($sformatf("res_ch%0d", id), ch, e.ch);
        chk($sformatf("res_data%0d", id), data, e.data);
        if (e.rise >= 0) chk($sformatf("valid_rise_cyc%0d", id), rise_c[id], e.rise);
      end
      if (ch == nch - 1) sd_pend[id] = 1;
    end
    prev_v[id] = int'(v);
  endtask

  always @(negedge clk) begin
    mon_step(0, reset, res_valid, res_ready, int'(res_ch), int'(res_data), scan_done, 4);
    mon_step(1, reset3, res_valid3, res_ready3, int'(res_ch3), int'(res_data3), scan_done3, 3);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic drain(input int id, input int budget, input string nm);
    int n = 0;
    while (qsize(id) != 0 && n < budget) begin
      tick();
      n++;
    end
    chk({nm, "_pending_results"}, qsize(id), 0);
    repeat (3) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int e0;

  initial begin
    reset = 1'b1; reset3 = 1'b1;
    enable = 1'b0; enable3 = 1'b0;
    res_ready = 1'b1; res_ready3 = 1'b1;
    conv_data = 8'h00; conv_data3 = 8'h5A;
    for (int i = 0; i < 2; i++) begin
      prev_v[i] = 0; rise_c[i] = 0; sd_pend[i] = 0; sd_cnt[i] = 0;
    end
    #2 reset = 1'b0; reset3 = 1'b0;
    #1;
    chk("rst_ch_sel", int'(ch_sel), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_ch", int'(res_ch), 0);
    chk("rst_res_data", int'(res_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_scan_done", int'(scan_done), 0);
    repeat (3) tick();
    reset = 1'b1; reset3 = 1'b1;
    repeat (3) tick();
    chk("idle_busy", int'(busy), 0);

    // Full scan of four channels at a constant level, stopping during ch 3.
    conv_data = 8'h80;
    enable = 1'b1; e0 = cyc + 1;
    for (int k = 0; k < 4; k++) push(0, k, 8'h80, e0 + 14 + 15 * k);
    tick();
    chk("scan_busy_after_e0", int'(busy), 1);
    wait_cyc(e0 + 50);
    enable = 1'b0;
    drain(0, 120, "scan");
    chk("scan_end_busy", int'(busy), 0);
    chk("scan_end_ch_sel", int'(ch_sel), 0);
    chk("scan_done_count", sd_cnt[0], 1);

    // Averaging with truncation, then full-scale samples.
    conv_data = 8'h02;
    enable = 1'b1; e0 = cyc + 1;
    push(0, 0, 8'h01, e0 + 14);
    push(0, 1, 8'hFF, e0 + 29);
    wait_cyc(e0 + 10); conv_data = 8'h01;
    wait_cyc(e0 + 11); conv_data = 8'h02;
    wait_cyc(e0 + 14); conv_data = 8'hFF;
    wait_cyc(e0 + 20); enable = 1'b0;
    drain(0, 80, "avg");
    chk("avg_end_busy", int'(busy), 0);

    // Backpressure on ch 0 for 20 cycles, then stop during ch 1 settle.
    conv_data = 8'h33;
    res_ready = 1'b0;
    enable = 1'b1; e0 = cyc + 1;
    push(0, 0, 8'h33, e0 + 14);
    push(0, 1, 8'h33, e0 + 49);
    wait_cyc(e0 + 14);
    conv_data = 8'h00;
    for (int k = 0; k < 20; k++) begin
      chk("bp_res_valid", int'(res_valid), 1);
      chk("bp_res_data", int'(res_data), 8'h33);
      chk("bp_res_ch", int'(res_ch), 0);
      chk("bp_ch_sel", int'(ch_sel), 0);
      tick();
    end
    res_ready = 1'b1;
    conv_data = 8'h33;
    wait_cyc(e0 + 38);
    enable = 1'b0;
    drain(0, 80, "stop");
    repeat (40) tick();
    chk("stop_busy", int'(busy), 0);
    chk("stop_ch_sel", int'(ch_sel), 0);
    chk("stop_res_valid", int'(res_valid), 0);

    // Asynchronous reset in the middle of ch 2 sampling.
    conv_data = 8'h80;
    enable = 1'b1; e0 = cyc + 1;
    push(0, 0, 8'h80, e0 + 14);
    push(0, 1, 8'h80, e0 + 29);
    wait_cyc(e0 + 41);
    chk("pre_rst_ch_sel", int'(ch_sel), 2);
    chk("pre_rst_res_ch", int'(res_ch), 1);
    chk("pre_rst_res_data", int'(res_data), 8'h80);
    chk("pre_rst_busy", int'(busy), 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_ch_sel", int'(ch_sel), 0);
    chk("mid_rst_res_valid", int'(res_valid), 0);
    chk("mid_rst_res_ch", int'(res_ch), 0);
    chk("mid_rst_res_data", int'(res_data), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_scan_done", int'(scan_done), 0);
    chk("mid_rst_pending", q0.size(), 0);
    repeat (2) tick();
    reset = 1'b1; e0 = cyc + 1;
    push(0, 0, 8'h80, e0 + 14);
    wait_cyc(e0 + 5);
    enable = 1'b0;
    drain(0, 60, "restart");
    chk("restart_busy", int'(busy), 0);

    // Three-channel instance: two full wraps.
    enable3 = 1'b1; e0 = cyc + 1;
    for (int k = 0; k < 6; k++) push(1, k % 3, 8'h5A, e0 + 4 + 5 * k);
    wait_cyc(e0 + 26);
    enable3 = 1'b0;
    drain(1, 60, "wrap");
    chk("wrap_scan_done_count", sd_cnt[1], 2);
    chk("wrap_busy", int'(busy3), 0);
    chk("wrap_ch_sel", int'(ch_sel3), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
